// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Immediate generator for the decode stage. For each accepted instruction it
//   produces the XLEN-wide immediate, an immediate-type code, an
//   illegal-encoding flag and the PC-relative target (pc + imm, wrapping).
//   Decode is combinational on the input side; results land in a 2-entry
//   output buffer (output register + skid register), so in_ready depends only
//   on the buffer state register and never on out_ready.
//
// Parameters
//   XLEN     datapath width, 32 or 64 (anything else stops elaboration)
//   ZIMM_EN  1: SYSTEM with funct3[2]=1 yields the CSR zimm (type Z)
//            0: every SYSTEM encoding yields type NONE
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, empties the buffer and drops this input
//   in_valid     in_inst/in_pc valid
//   in_ready     block accepts this cycle (low only when the buffer is full)
//   in_inst      32-bit instruction word
//   in_pc        instruction address
//   out_valid    out_* fields valid
//   out_ready    downstream accepts
//   out_imm      immediate, sign/zero-extended to XLEN
//   out_type     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal  unsupported opcode or inst[1:0] != 2'b11
//   out_target   in_pc + out_imm modulo 2^XLEN
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int ZIMM_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Every RISC-V immediate fits in 32 signed bits; it is assembled at that
  // width and then sign-extended once, which also gives the XLEN=64
  // sign-extension of U-type for free. zimm is built non-negative, so the same
  // extension zero-extends it.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t              d;
    logic signed [31:0] imm32;
    logic               s;
    s         = inst[31];
    imm32     = '0;
    d.ty      = T_NONE;
    d.illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
          d.ty  = T_I;
          imm32 = {{20{s}}, inst[31:20]};
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            d.ty  = T_I;
            imm32 = {{20{s}}, inst[31:20]};
          end else begin
            d.illegal = 1'b1;
          end
        end
        7'b0100011: begin
          d.ty  = T_S;
          imm32 = {{20{s}}, inst[31:25], inst[11:7]};
        end
        7'b1100011: begin
          d.ty  = T_B;
          imm32 = {{20{s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          d.ty  = T_U;
          imm32 = {inst[31:12], 12'b0};
        end
        7'b1101111: begin
          d.ty  = T_J;
          imm32 = {{12{s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        7'b0110011: begin
          d.ty = T_NONE;
        end
        7'b0111011: begin
          if (XLEN != 64) d.illegal = 1'b1;
        end
        7'b1110011: begin
          if (ZIMM_EN != 0 && inst[14]) begin
            d.ty  = T_Z;
            imm32 = {27'b0, inst[19:15]};
          end
        end
        default: begin
          d.illegal = 1'b1;
        end
      endcase
    end
    d.imm = XLEN'(imm32);
    return d;
  endfunction

  // ---- stage p0: combinational decode and target add on the input ----
  dec_t            dec_p0;
  logic [XLEN-1:0] tgt_p0;
  logic            accept_p0;

  always_comb begin
    dec_p0 = decode(in_inst);
    tgt_p0 = in_pc + dec_p0.imm;
  end

  assign accept_p0 = in_valid && in_ready && !flush;

  // ---- stage p1: two-entry output buffer (output register + skid) ----
  buf_state_t state_p1, state_nxt;
  logic       load_out, load_skid, skid_to_out;

  dec_t            skid_dec_p1;
  logic [XLEN-1:0] skid_tgt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= EMPTY;
    else        state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_p1;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept_p0) begin
            state_nxt = ONE;
            load_out  = 1'b1;
          end
        end
        ONE: begin
          if (accept_p0 && out_ready) begin
            load_out = 1'b1;
          end else if (accept_p0) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing new can arrive alongside.
          if (out_ready) begin
            state_nxt   = ONE;
            skid_to_out = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm     <= '0;
      out_type    <= T_NONE;
      out_illegal <= 1'b0;
      out_target  <= '0;
      skid_dec_p1 <= '0;
      skid_tgt_p1 <= '0;
    end else begin
      if (load_out) begin
        out_imm     <= dec_p0.imm;
        out_type    <= dec_p0.ty;
        out_illegal <= dec_p0.illegal;
        out_target  <= tgt_p0;
      end else if (skid_to_out) begin
        out_imm     <= skid_dec_p1.imm;
        out_type    <= skid_dec_p1.ty;
        out_illegal <= skid_dec_p1.illegal;
        out_target  <= skid_tgt_p1;
      end
      if (load_skid) begin
        skid_dec_p1 <= dec_p0;
        skid_tgt_p1 <= tgt_p0;
      end
    end
  end

  assign out_valid = (state_p1 != EMPTY);
  assign in_ready  = (state_p1 != FULL);

endmodule
